// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, funct/ALUOp encodings, mul/div FSM states and decode.
package alu_pkg;
    localparam logic [3:0] CTRL_AND    = 4'b0000;
    localparam logic [3:0] CTRL_OR     = 4'b0001;
    localparam logic [3:0] CTRL_ADD    = 4'b0010;
    localparam logic [3:0] CTRL_HILO   = 4'b0011;
    localparam logic [3:0] CTRL_SUB    = 4'b0110;
    localparam logic [3:0] CTRL_SLT    = 4'b0111;
    localparam logic [3:0] CTRL_MULDIV = 4'b1000;
    localparam logic [3:0] CTRL_XOR    = 4'b1001;
    localparam logic [3:0] CTRL_ILL    = 4'b1111;

    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_FUNCT = 2'b10;
    localparam logic [1:0] OP_SLT   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] f, input logic div_en);
        if (op == OP_ADD) return CTRL_ADD;
        if (op == OP_SUB) return CTRL_SUB;
        if (op == OP_SLT) return CTRL_SLT;
        case (f)
            F_ADD:          return CTRL_ADD;
            F_SUB:          return CTRL_SUB;
            F_AND:          return CTRL_AND;
            F_OR:           return CTRL_OR;
            F_XOR:          return CTRL_XOR;
            F_SLT:          return CTRL_SLT;
            F_MULT, F_MULTU: return CTRL_MULDIV;
            F_DIV, F_DIVU:  return div_en ? CTRL_MULDIV : CTRL_ILL;
            F_MFHI, F_MFLO: return CTRL_HILO;
            default:        return CTRL_ILL;
        endcase
    endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiply / restoring divide on magnitudes, owning HI/LO.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] res_o
);
    localparam int CW = $clog2(WIDTH);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] p_q, prod;
    logic [WIDTH-1:0]   m_q, hi_q, lo_q, hi_d, lo_d, quo, rem, mag1, mag2;
    logic               s1_q, s2_q, div_q, s1, s2, ge;
    logic [WIDTH:0]     add_sum, rem_sh, rem_sub;

    assign s1   = signed_i & a_i[WIDTH-1];
    assign s2   = signed_i & b_i[WIDTH-1];
    assign mag1 = s1 ? -a_i : a_i;
    assign mag2 = s2 ? -b_i : b_i;

    // p_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide
    assign add_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, p_q[0] ? m_q : '0};
    assign rem_sh  = p_q[2*WIDTH-1:WIDTH-1];
    assign rem_sub = rem_sh - {1'b0, m_q};
    assign ge      = !rem_sub[WIDTH];

    assign prod = (s1_q ^ s2_q) ? -p_q : p_q;
    assign quo  = (s1_q ^ s2_q) ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign rem  = s1_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    assign hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
    assign lo_d = !div_q ? prod[WIDTH-1:0] : (m_q == '0) ? '1 : quo;

    assign busy_o = state_q != S_IDLE;
    assign done_o = state_q == S_FIX;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign res_o  = lo_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q <= div_i ? S_DIV : S_MUL;
                    cnt_q   <= '0;
                    m_q     <= div_i ? mag2 : mag1;
                    p_q     <= {{WIDTH{1'b0}}, div_i ? mag1 : mag2};
                    s1_q    <= s1;
                    s2_q    <= s2;
                    div_q   <= div_i;
                end
                S_MUL, S_DIV: begin
                    p_q   <= (state_q == S_MUL) ? {add_sum, p_q[WIDTH-1:1]}
                           : {ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU control decode, single-cycle datapath and registered results,
// with multiply/divide delegated to the iterative HI/LO unit.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter bit SUPPORT_DIV = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [3:0]       ALUCtrl_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             illegal_o
);
    logic             accept, start, md_busy, md_done;
    logic             valid_d, illegal_d, valid_q, illegal_q, zero_q;
    logic [WIDTH-1:0] hi, lo, md_res, alu_res, result_d, result_q;

    assign ALUCtrl_o = decode(ALUOp_i, funct_i, SUPPORT_DIV);
    assign ready_o   = !md_busy;
    assign accept    = valid_i && ready_o;
    assign start     = accept && ALUCtrl_o == CTRL_MULDIV;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start),
        .div_i    (funct_i[1]),
        .signed_i (!funct_i[0]),
        .a_i      (src1_i),
        .b_i      (src2_i),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .hi_o     (hi),
        .lo_o     (lo),
        .res_o    (md_res)
    );

    always_comb begin
        alu_res = '0;
        case (ALUCtrl_o)
            CTRL_ADD:  alu_res = src1_i + src2_i;
            CTRL_SUB:  alu_res = src1_i - src2_i;
            CTRL_AND:  alu_res = src1_i & src2_i;
            CTRL_OR:   alu_res = src1_i | src2_i;
            CTRL_XOR:  alu_res = src1_i ^ src2_i;
            CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            CTRL_HILO: alu_res = (funct_i == F_MFHI) ? hi : lo;
            default:   alu_res = '0;
        endcase
    end

    // accept cannot coincide with md_done since ready_o is low in FIX
    assign valid_d   = md_done || (accept && !start);
    assign result_d  = md_done ? md_res : alu_res;
    assign illegal_d = !md_done && accept && ALUCtrl_o == CTRL_ILL;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            if (valid_d) begin
                result_q <= result_d;
                zero_q   <= result_d == '0;
            end
        end
    end

    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign illegal_o = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with a scoreboard queue; a negedge monitor checks every valid_o.
module tb_alu_exec_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        valid_nd = 1'b0;
    logic [1:0]  ALUOp_i = 2'b00;
    logic [5:0]  funct_i = 6'h00;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        ready_o, valid_o, zero_o, illegal_o;
    logic [3:0]  ALUCtrl_o;
    logic [31:0] result_o;
    logic        nd_ready, nd_valid, nd_zero, nd_illegal;
    logic [3:0]  nd_ctrl;
    logic [31:0] nd_result;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    alu_exec_unit #(.WIDTH(32), .SUPPORT_DIV(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
        .ALUCtrl_o(ALUCtrl_o), .valid_o(valid_o), .result_o(result_o),
        .zero_o(zero_o), .illegal_o(illegal_o)
    );

    alu_exec_unit #(.WIDTH(32), .SUPPORT_DIV(1'b0)) dut_nd (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_nd), .ready_o(nd_ready),
        .ALUOp_i(ALUOp_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
        .ALUCtrl_o(nd_ctrl), .valid_o(nd_valid), .result_o(nd_result),
        .zero_o(nd_zero), .illegal_o(nd_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i && valid_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got result %h expected no valid_o at %0t", result_o, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result_o, e.res);
                chk("zero", {31'b0, zero_o}, {31'b0, e.z});
                chk("illegal", {31'b0, illegal_o}, {31'b0, e.ill});
            end
        end
    end

    // called at a negedge; returns at the following negedge with valid_i still asserted
    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] ctrl, input logic [31:0] er, input logic ei);
        ALUOp_i = op;
        funct_i = f;
        src1_i  = a;
        src2_i  = b;
        valid_i = 1'b1;
        #1;
        chk("alu_ctrl", {28'b0, ALUCtrl_o}, {28'b0, ctrl});
        sb.push_back('{res: er, z: (er == 32'h0), ill: ei});
        @(negedge clk_i);
    endtask

    task automatic idle();
        valid_i = 1'b0;
        @(negedge clk_i);
    endtask

    // leaves the bench at the negedge of the valid_o cycle so the next issue sees fresh HI/LO
    task automatic wait_done();
        int cnt = 0;
        valid_i = 1'b0;
        while (!ready_o && cnt < 40) begin
            cnt++;
            @(negedge clk_i);
        end
        chk("busy_cycles", cnt, 33);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_zero", {31'b0, zero_o}, 32'h0);
        chk("rst_illegal", {31'b0, illegal_o}, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", {31'b0, ready_o}, 32'h1);

        issue(2'b10, 6'h20, 32'd7, 32'd5, 4'b0010, 32'd12, 1'b0);
        issue(2'b11, 6'h00, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0);
        issue(2'b01, 6'h00, 32'd5, 32'd5, 4'b0110, 32'd0, 1'b0);
        issue(2'b10, 6'h24, 32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 32'h0000_F000, 1'b0);
        issue(2'b10, 6'h25, 32'h0000_F0F0, 32'h0000_FF00, 4'b0001, 32'h0000_FFF0, 1'b0);
        issue(2'b10, 6'h26, 32'h0000_F0F0, 32'h0000_FF00, 4'b1001, 32'h0000_0FF0, 1'b0);
        issue(2'b10, 6'h2A, 32'd3, 32'hFFFF_FFFE, 4'b0111, 32'd0, 1'b0);
        issue(2'b00, 6'h3F, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b0);
        idle();

        issue(2'b10, 6'h18, 32'hFFFF_FFFF, 32'd2, 4'b1000, 32'hFFFF_FFFE, 1'b0);
        wait_done();
        issue(2'b10, 6'h10, 32'd0, 32'd0, 4'b0011, 32'hFFFF_FFFF, 1'b0);
        issue(2'b10, 6'h12, 32'd0, 32'd0, 4'b0011, 32'hFFFF_FFFE, 1'b0);
        idle();

        issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'd2, 4'b1000, 32'hFFFF_FFFE, 1'b0);
        wait_done();
        issue(2'b10, 6'h10, 32'd0, 32'd0, 4'b0011, 32'd1, 1'b0);

        issue(2'b10, 6'h1A, 32'hFFFF_FFF9, 32'd2, 4'b1000, 32'hFFFF_FFFD, 1'b0);
        wait_done();
        issue(2'b10, 6'h10, 32'd0, 32'd0, 4'b0011, 32'hFFFF_FFFF, 1'b0);

        issue(2'b10, 6'h1B, 32'd7, 32'd0, 4'b1000, 32'hFFFF_FFFF, 1'b0);
        wait_done();
        issue(2'b10, 6'h10, 32'd0, 32'd0, 4'b0011, 32'd7, 1'b0);

        issue(2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1000, 32'h8000_0000, 1'b0);
        wait_done();
        issue(2'b10, 6'h10, 32'd0, 32'd0, 4'b0011, 32'd0, 1'b0);

        issue(2'b10, 6'h3F, 32'd9, 32'd9, 4'b1111, 32'd0, 1'b1);
        idle();

        ALUOp_i  = 2'b10;
        funct_i  = 6'h1A;
        src1_i   = 32'd9;
        src2_i   = 32'd3;
        valid_nd = 1'b1;
        #1;
        chk("nodiv_ctrl", {28'b0, nd_ctrl}, 32'hF);
        chk("div_ctrl", {28'b0, ALUCtrl_o}, 32'h8);
        @(negedge clk_i);
        valid_nd = 1'b0;
        chk("nodiv_valid", {31'b0, nd_valid}, 32'h1);
        chk("nodiv_illegal", {31'b0, nd_illegal}, 32'h1);
        chk("nodiv_result", nd_result, 32'h0);
        chk("nodiv_ready", {31'b0, nd_ready}, 32'h1);

        issue(2'b10, 6'h20, 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0);
        issue(2'b10, 6'h18, 32'd6, 32'd7, 4'b1000, 32'd42, 1'b0);
        valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        chk("mid_busy", {31'b0, ready_o}, 32'h0);
        rst_i = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("abort_valid", {31'b0, valid_o}, 32'h0);
        chk("abort_result", result_o, 32'h0);
        chk("abort_zero", {31'b0, zero_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (40) @(negedge clk_i);
        chk("abort_ready", {31'b0, ready_o}, 32'h1);
        issue(2'b10, 6'h10, 32'd0, 32'd0, 4'b0011, 32'd0, 1'b0);
        issue(2'b10, 6'h12, 32'd0, 32'd0, 4'b0011, 32'd0, 1'b0);
        idle();

        repeat (3) @(negedge clk_i);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
